// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding and default timing constants for stopwatch_ctrl
`timescale 1ns/1ps
package stopwatch_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10,
        LAP  = 2'b11
    } sw_state_t;
    localparam int TICK_DIV_DEF = 320000;
    localparam int DEB_DIV_DEF  = 32000;
    localparam int DEB_CNT_DEF  = 4;
endpackage

// File: rtl/stopwatch_ctrl_sw_debounce.sv
// sw_debounce: 2-flop synchroniser, strobed sample counting and press pulse for one active-low switch
`timescale 1ns/1ps
module sw_debounce import stopwatch_pkg::*; #(
    parameter int DEB_CNT = DEB_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_n,
    input  logic stb,
    output logic press
);
    localparam int CW = DEB_CNT > 1 ? $clog2(DEB_CNT) : 1;
    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;
    assign differ = sync[1] != level;
    assign accept = stb && differ && cnt == CW'(DEB_CNT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], sw_n};
            press <= accept && level;
            if (accept) level <= ~level;
            // any sample matching the current level restarts the run of differing samples
            cnt   <= !stb ? cnt : (!differ || accept) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: switch debounce, start/stop/lap/clear FSM and 10 ms tick prescaler.
// Lap feature is built only when STOPWATCH_LAP_EN is defined.
`timescale 1ns/1ps
module stopwatch_ctrl import stopwatch_pkg::*; #(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DEB_DIV  = DEB_DIV_DEF,
    parameter int DEB_CNT  = DEB_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_start_n,
    input  logic       sw_clear_n,
    output logic       tick_10ms,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic       led,
    output logic [1:0] state
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int DW = DEB_DIV > 1 ? $clog2(DEB_DIV) : 1;
    logic [DW-1:0] deb_div;
    logic          deb_stb;
    logic          start_ev;
    logic          clear_ev;
    logic [PW-1:0] presc;
    logic          running;
    logic          wrap;
    logic          clr_d;
    sw_state_t     state_q;
    sw_state_t     state_d;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) disp_hold <= 1'b0;
        else     disp_hold <= state_d == LAP;
    end
`else
    localparam bit LAP_EN = 1'b0;
    assign disp_hold = 1'b0;
`endif
    assign deb_stb = deb_div == DW'(DEB_DIV - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) deb_div <= '0;
        else     deb_div <= deb_stb ? '0 : deb_div + 1'b1;
    end
    sw_debounce #(.DEB_CNT(DEB_CNT)) u_start (
        .clk   (clk),
        .rst   (rst),
        .sw_n  (sw_start_n),
        .stb   (deb_stb),
        .press (start_ev)
    );
    sw_debounce #(.DEB_CNT(DEB_CNT)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .sw_n  (sw_clear_n),
        .stb   (deb_stb),
        .press (clear_ev)
    );
    assign running = state_q == RUN || state_q == LAP;
    assign wrap    = presc == PW'(TICK_DIV - 1);
    // start has priority; a clear arriving in the same cycle is dropped
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        if (start_ev) begin
            state_d = running ? STOP : RUN;
        end else if (clear_ev) begin
            case (state_q)
                IDLE, STOP: begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
                RUN:     state_d = LAP_EN ? LAP : RUN;
                default: state_d = RUN;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_clr   <= 1'b0;
            led       <= 1'b0;
            tick_10ms <= 1'b0;
            presc     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_clr   <= clr_d;
            led       <= state_d == RUN || state_d == LAP;
            tick_10ms <= running && wrap;
            // holding in STOP keeps the partial tick for the resume
            presc     <= clr_d ? '0 : !running ? presc : wrap ? '0 : presc + 1'b1;
        end
    end
    assign state = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized self-checking bench for stopwatch_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
    localparam int TD = 10;
    localparam int DD = 4;
    localparam int DC = 3;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_STOP = 2, ST_LAP = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_start_n = 1'b1;
    logic       sw_clear_n = 1'b1;
    logic       tick_10ms;
    logic       cnt_clr;
    logic       disp_hold;
    logic       led;
    logic [1:0] state;
    int checks = 0;
    int errors = 0;
    int m_state = ST_IDLE;
    bit mon_en = 1'b0;
    int run_n = 0;
    bit last_run = 1'b0;
    bit mon_exp;

    stopwatch_ctrl #(.TICK_DIV(TD), .DEB_DIV(DD), .DEB_CNT(DC)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_start_n (sw_start_n),
        .sw_clear_n (sw_clear_n),
        .tick_10ms  (tick_10ms),
        .cnt_clr    (cnt_clr),
        .disp_hold  (disp_hold),
        .led        (led),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic int model_start(input int s);
        return (s == ST_RUN || s == ST_LAP) ? ST_STOP : ST_RUN;
    endfunction

    function automatic int model_clear(input int s);
        if (s == ST_IDLE || s == ST_STOP) return ST_IDLE;
        if (s == ST_RUN) return LAP_ON ? ST_LAP : ST_RUN;
        return ST_RUN;
    endfunction

    // ticks: one every TD cycles of accumulated running time since the last clear/reset
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp = last_run && (run_n % TD == 0);
            checks++;
            if (tick_10ms !== mon_exp) begin
                errors++;
                $display("FAIL tick_monitor t=%0t got %b expected %b", $time, tick_10ms, mon_exp);
            end
            if (!LAP_ON) begin
                checks++;
                if (state === 2'b11) begin
                    errors++;
                    $display("FAIL no_lap_encoding t=%0t got %b expected not 11", $time, state);
                end
            end
            if (state === 2'b00) begin
                run_n = 0;
                last_run = 1'b0;
            end else if (state === 2'b01 || state === 2'b11) begin
                run_n++;
                last_run = 1'b1;
            end else begin
                last_run = 1'b0;
            end
        end
    end

    task automatic do_press(input bit s, input bit c, input int hold, output int clr_cnt);
        clr_cnt = 0;
        sw_start_n = ~s;
        sw_clear_n = ~c;
        repeat (hold) begin
            @(negedge clk);
            if (cnt_clr) clr_cnt++;
        end
        sw_start_n = 1'b1;
        sw_clear_n = 1'b1;
        repeat (24) begin
            @(negedge clk);
            if (cnt_clr) clr_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b expected 00", state); end
        if (tick_10ms !== 1'b0) begin errors++; $display("FAIL reset_tick got %b expected 0", tick_10ms); end
        if (cnt_clr !== 1'b0) begin errors++; $display("FAIL reset_cnt_clr got %b expected 0", cnt_clr); end
        if (disp_hold !== 1'b0) begin errors++; $display("FAIL reset_disp_hold got %b expected 0", disp_hold); end
        if (led !== 1'b0) begin errors++; $display("FAIL reset_led got %b expected 0", led); end
        rst = 1'b0;
        run_n = 0;
        last_run = 1'b0;
        mon_en = 1'b1;
        m_state = ST_IDLE;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_start_tick;
        int k, j;
        k = 0;
        sw_start_n = 1'b0;
        while (state !== 2'b01 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks += 3;
        if (state !== 2'b01 || k > 16) begin errors++; $display("FAIL start_latency got state %b after %0d cycles expected 01 within 16", state, k); end
        if (led !== 1'b1) begin errors++; $display("FAIL start_led got %b expected 1", led); end
        if (disp_hold !== 1'b0) begin errors++; $display("FAIL start_disp_hold got %b expected 0", disp_hold); end
        for (int t = 0; t < 2; t++) begin
            j = 0;
            do begin
                @(negedge clk);
                j++;
            end while (!tick_10ms && j < 15);
            checks++;
            if (j != TD) begin errors++; $display("FAIL tick_period%0d got %0d cycles expected %0d", t, j, TD); end
        end
        repeat (40 - k - 2 * TD) @(negedge clk);
        sw_start_n = 1'b1;
        repeat (24) @(negedge clk);
        m_state = ST_RUN;
    endtask

    task automatic test_glitch_pause;
        int len, c, r, k, j, n;
        for (int g = 0; g < 2; g++) begin
            len = $urandom_range(1, (DC - 1) * DD - 1);
            if (g == 0) sw_start_n = 1'b0; else sw_clear_n = 1'b0;
            repeat (len) @(negedge clk);
            sw_start_n = 1'b1;
            sw_clear_n = 1'b1;
            repeat (24) @(negedge clk);
            checks++;
            if (state !== 2'b01) begin errors++; $display("FAIL glitch%0d len=%0d got state %b expected 01", g, len, state); end
        end
        do_press(1'b1, 1'b0, $urandom_range(14, 30), c);
        m_state = ST_STOP;
        checks += 3;
        if (state !== 2'b10) begin errors++; $display("FAIL pause_state got %b expected 10", state); end
        if (led !== 1'b0) begin errors++; $display("FAIL pause_led got %b expected 0", led); end
        if (c != 0) begin errors++; $display("FAIL pause_cnt_clr got %0d pulses expected 0", c); end
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick_10ms) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL pause_ticks got %0d expected 0", n); end
        r = TD - (run_n % TD);
        k = 0;
        sw_start_n = 1'b0;
        while (state !== 2'b01 && k < 20) begin
            @(negedge clk);
            k++;
        end
        j = 0;
        do begin
            @(negedge clk);
            j++;
        end while (!tick_10ms && j < 15);
        checks++;
        if (j != r) begin errors++; $display("FAIL resume_first_tick got %0d cycles expected %0d", j, r); end
        repeat (30) @(negedge clk);
        sw_start_n = 1'b1;
        repeat (24) @(negedge clk);
        m_state = ST_RUN;
    endtask

    task automatic test_clear;
        int c, k, j;
        do_press(1'b1, 1'b0, $urandom_range(14, 30), c);
        m_state = ST_STOP;
        k = 0;
        sw_clear_n = 1'b0;
        while (state !== 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks += 3;
        if (state !== 2'b00) begin errors++; $display("FAIL clear_state got %b expected 00", state); end
        if (cnt_clr !== 1'b1) begin errors++; $display("FAIL clear_pulse_align got %b expected 1", cnt_clr); end
        @(negedge clk);
        if (cnt_clr !== 1'b0) begin errors++; $display("FAIL clear_pulse_width got %b expected 0", cnt_clr); end
        repeat (10) @(negedge clk);
        sw_clear_n = 1'b1;
        repeat (24) @(negedge clk);
        m_state = ST_IDLE;
        k = 0;
        sw_start_n = 1'b0;
        while (state !== 2'b01 && k < 20) begin
            @(negedge clk);
            k++;
        end
        j = 0;
        do begin
            @(negedge clk);
            j++;
        end while (!tick_10ms && j < 15);
        checks++;
        if (j != TD) begin errors++; $display("FAIL clear_first_tick got %0d cycles expected %0d", j, TD); end
        repeat (8) @(negedge clk);
        sw_start_n = 1'b1;
        repeat (24) @(negedge clk);
        m_state = ST_RUN;
    endtask

    task automatic test_lap;
        int c, n, e;
        e = model_clear(m_state);
        do_press(1'b0, 1'b1, $urandom_range(14, 30), c);
        m_state = e;
        checks += 4;
        if (state !== 2'(e)) begin errors++; $display("FAIL lap_state got %b expected %0d", state, e); end
        if (disp_hold !== LAP_ON) begin errors++; $display("FAIL lap_disp_hold got %b expected %b", disp_hold, LAP_ON); end
        if (led !== 1'b1) begin errors++; $display("FAIL lap_led got %b expected 1", led); end
        if (c != 0) begin errors++; $display("FAIL lap_cnt_clr got %0d pulses expected 0", c); end
        n = 0;
        repeat (3 * TD) begin
            @(negedge clk);
            if (tick_10ms) n++;
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL lap_ticks got %0d expected 3", n); end
        do_press(1'b1, 1'b0, $urandom_range(14, 30), c);
        m_state = ST_STOP;
        checks += 2;
        if (state !== 2'b10) begin errors++; $display("FAIL lap_stop_state got %b expected 10", state); end
        if (disp_hold !== 1'b0) begin errors++; $display("FAIL lap_stop_disp_hold got %b expected 0", disp_hold); end
    endtask

    task automatic test_simultaneous;
        int c;
        do_press(1'b1, 1'b0, $urandom_range(14, 30), c);
        m_state = ST_RUN;
        do_press(1'b1, 1'b1, $urandom_range(14, 30), c);
        m_state = ST_STOP;
        checks += 3;
        if (state !== 2'b10) begin errors++; $display("FAIL simul_state got %b expected 10", state); end
        if (c != 0) begin errors++; $display("FAIL simul_cnt_clr got %0d pulses expected 0", c); end
        if (disp_hold !== 1'b0) begin errors++; $display("FAIL simul_disp_hold got %b expected 0", disp_hold); end
    endtask

    task automatic test_random;
        int op, e, ec, c;
        bit s, cl;
        for (int i = 0; i < 12; i++) begin
            op = $urandom_range(0, 2);
            s  = op != 1;
            cl = op != 0;
            e  = s ? model_start(m_state) : model_clear(m_state);
            ec = (!s && cl && (m_state == ST_IDLE || m_state == ST_STOP)) ? 1 : 0;
            do_press(s, cl, $urandom_range(14, 30), c);
            checks += 4;
            if (state !== 2'(e)) begin errors++; $display("FAIL rand%0d_state op=%0d from %0d got %b expected %0d", i, op, m_state, state, e); end
            if (c != ec) begin errors++; $display("FAIL rand%0d_cnt_clr got %0d expected %0d", i, c, ec); end
            if (led !== (e == ST_RUN || e == ST_LAP)) begin errors++; $display("FAIL rand%0d_led got %b for model state %0d", i, led, e); end
            if (disp_hold !== (e == ST_LAP)) begin errors++; $display("FAIL rand%0d_disp_hold got %b for model state %0d", i, disp_hold, e); end
            m_state = e;
        end
    endtask

    task automatic test_reset_mid;
        int c;
        if (m_state != ST_RUN && m_state != ST_LAP) begin
            do_press(1'b1, 1'b0, 20, c);
            m_state = model_start(m_state);
        end
        mon_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 5;
        if (state !== 2'b00) begin errors++; $display("FAIL async_reset_state got %b expected 00", state); end
        if (tick_10ms !== 1'b0) begin errors++; $display("FAIL async_reset_tick got %b expected 0", tick_10ms); end
        if (cnt_clr !== 1'b0) begin errors++; $display("FAIL async_reset_cnt_clr got %b expected 0", cnt_clr); end
        if (disp_hold !== 1'b0) begin errors++; $display("FAIL async_reset_disp_hold got %b expected 0", disp_hold); end
        if (led !== 1'b0) begin errors++; $display("FAIL async_reset_led got %b expected 0", led); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_n = 0;
        last_run = 1'b0;
        mon_en = 1'b1;
        m_state = ST_IDLE;
        do_press(1'b1, 1'b0, $urandom_range(14, 30), c);
        m_state = ST_RUN;
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL after_reset_start got %b expected 01", state); end
    endtask

    initial begin
        test_reset;
        test_start_tick;
        test_glitch_pause;
        test_clear;
        test_lap;
        test_simultaneous;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
